// File: rtl/wavetable_slot_allocator.sv
// wavetable_slot_allocator
// Maps up to NUM_VOICES gated oscillator phases onto NUM_SLOTS persistent
// wavetable read slots. One voice is scanned per cycle after each sample
// tick. A coherent address/fraction set is published once per pass.
// Optional feature macro: VOICE_STEAL_EN. When it is defined, a new note
// steals the oldest slot if all slots are full. When it is undefined, the
// note is dropped and retried on the next pass.
module wavetable_slot_allocator #(
    parameter int NUM_VOICES  = 8,
    parameter int NUM_SLOTS   = 4,
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int FRAC_WIDTH  = 8,
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int NW = $clog2(NUM_SLOTS + 1)
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic                                   sample_tick_in,
    input  logic [NUM_VOICES-1:0][PHASE_WIDTH-1:0] phase_in,
    input  logic [NUM_VOICES-1:0]                  gate_in,
    output logic [NUM_SLOTS-1:0][ADDR_WIDTH-1:0]   addr_out,
    output logic [NUM_SLOTS-1:0][FRAC_WIDTH-1:0]   frac_out,
    output logic [NUM_SLOTS-1:0][VW-1:0]           slot_voice_out,
    output logic [NUM_SLOTS-1:0]                   slot_valid_out,
    output logic [NUM_VOICES-1:0]                  active_voices_out,
    output logic [NW-1:0]                          num_voices_out,
    output logic                                   valid_out,
    output logic                                   steal_out,
    output logic                                   overrun_out
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = ADDR_WIDTH + FRAC_WIDTH;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SCAN    = 2'd1;
    localparam logic [1:0] S_PUBLISH = 2'd2;

`ifdef VOICE_STEAL_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? a : a + 8'd1;
    endfunction
`endif

    logic [1:0]                           r_state;
    logic [VW-1:0]                        r_idx;
    logic [NUM_VOICES-1:0]                r_gate_p0;
    logic [NUM_VOICES-1:0][TW-1:0]        r_phase_p0;
    logic [NUM_SLOTS-1:0]                 r_slot_valid;
    logic [NUM_SLOTS-1:0][VW-1:0]         r_slot_owner;
`ifdef VOICE_STEAL_EN
    logic [NUM_SLOTS-1:0][7:0]            r_slot_age;
    logic                                 r_steal_flag;
    logic                                 w_old_found;
    logic [SW-1:0]                        w_old_idx;
    logic [7:0]                           w_old_age;
`endif

    logic                                 w_hold_found;
    logic [SW-1:0]                        w_hold_idx;
    logic                                 w_free_found;
    logic [SW-1:0]                        w_free_idx;
    logic [NUM_VOICES-1:0]                w_active;
    logic [NW-1:0]                        w_count;

    // Only the address and fraction bits of each phase are ever read.
    generate
        if (PHASE_WIDTH > TW) begin : g_lsb_sink
            logic w_unused_phase_lsbs;
            always_comb begin
                w_unused_phase_lsbs = 1'b0;
                for (int v = 0; v < NUM_VOICES; v++)
                    w_unused_phase_lsbs = w_unused_phase_lsbs ^ (^phase_in[v][PHASE_WIDTH-TW-1:0]);
            end
        end
    endgenerate

    // A new tick while a pass is running is dropped and flagged in the same cycle.
    assign overrun_out = sample_tick_in && (r_state != S_IDLE);

    // Snapshot of the gated voices and their phases, taken when a pass starts.
    always_ff @(posedge clk_in) begin
        if (r_state == S_IDLE && sample_tick_in) begin
            r_gate_p0 <= gate_in;
            for (int v = 0; v < NUM_VOICES; v++)
                r_phase_p0[v] <= phase_in[v][PHASE_WIDTH-1 -: TW];
        end
    end

    // Slot lookups for the voice under scan: held slot, lowest free slot, oldest slot.
    always_comb begin
        w_hold_found = 1'b0;
        w_hold_idx   = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
`ifdef VOICE_STEAL_EN
        w_old_found  = 1'b0;
        w_old_idx    = '0;
        w_old_age    = '0;
`endif
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_slot_valid[s] && (r_slot_owner[s] == r_idx)) begin
                w_hold_found = 1'b1;
                w_hold_idx   = SW'(s);
            end
            if (!r_slot_valid[s] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = SW'(s);
            end
`ifdef VOICE_STEAL_EN
            // Strictly-greater keeps the lowest index on equal ages.
            if (r_slot_valid[s] && (!w_old_found || (r_slot_age[s] > w_old_age))) begin
                w_old_found = 1'b1;
                w_old_idx   = SW'(s);
                w_old_age   = r_slot_age[s];
            end
`endif
        end
    end

    // Per-voice activity and slot occupancy count for publication.
    always_comb begin
        w_active = '0;
        w_count  = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (r_slot_valid[s]) begin
                w_count = w_count + NW'(r_slot_valid[s]);
                if (r_gate_p0[r_slot_owner[s]])
                    w_active[r_slot_owner[s]] = 1'b1;
            end
        end
    end

    // Pass sequencer: scan one voice per cycle, then publish the slot table.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state           <= S_IDLE;
            r_idx             <= '0;
            r_slot_valid      <= '0;
            r_slot_owner      <= '0;
`ifdef VOICE_STEAL_EN
            r_slot_age        <= '0;
            r_steal_flag      <= 1'b0;
            steal_out         <= 1'b0;
`endif
            addr_out          <= '0;
            frac_out          <= '0;
            slot_voice_out    <= '0;
            slot_valid_out    <= '0;
            active_voices_out <= '0;
            num_voices_out    <= '0;
            valid_out         <= 1'b0;
        end else begin
            valid_out <= 1'b0;
`ifdef VOICE_STEAL_EN
            steal_out <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (sample_tick_in) begin
                        r_state <= S_SCAN;
                        r_idx   <= '0;
`ifdef VOICE_STEAL_EN
                        r_steal_flag <= 1'b0;
`endif
                    end
                end
                // ---- scan stage: one voice per cycle ----
                S_SCAN: begin
                    if (r_gate_p0[r_idx]) begin
                        if (!w_hold_found) begin
                            if (w_free_found) begin
                                r_slot_valid[w_free_idx] <= 1'b1;
                                r_slot_owner[w_free_idx] <= r_idx;
`ifdef VOICE_STEAL_EN
                                r_slot_age[w_free_idx]   <= 8'd0;
`endif
                            end
`ifdef VOICE_STEAL_EN
                            else if (w_old_found) begin
                                r_slot_owner[w_old_idx] <= r_idx;
                                r_slot_age[w_old_idx]   <= 8'd0;
                                r_steal_flag            <= 1'b1;
                            end
`endif
                        end
                    end else if (w_hold_found) begin
                        r_slot_valid[w_hold_idx] <= 1'b0;
`ifdef VOICE_STEAL_EN
                        r_slot_age[w_hold_idx]   <= 8'd0;
`endif
                    end
                    if (r_idx == VW'(NUM_VOICES - 1))
                        r_state <= S_PUBLISH;
                    else
                        r_idx <= r_idx + VW'(1);
                end
                // ---- publish stage: register the coherent output set ----
                S_PUBLISH: begin
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (r_slot_valid[s]) begin
                            addr_out[s]       <= r_phase_p0[r_slot_owner[s]][TW-1 -: ADDR_WIDTH];
                            frac_out[s]       <= r_phase_p0[r_slot_owner[s]][FRAC_WIDTH-1:0];
                            slot_voice_out[s] <= r_slot_owner[s];
`ifdef VOICE_STEAL_EN
                            r_slot_age[s]     <= sat_inc8(r_slot_age[s]);
`endif
                        end else begin
                            addr_out[s]       <= '0;
                            frac_out[s]       <= '0;
                            slot_voice_out[s] <= '0;
                        end
                    end
                    slot_valid_out    <= r_slot_valid;
                    active_voices_out <= w_active;
                    num_voices_out    <= w_count;
                    valid_out         <= 1'b1;
`ifdef VOICE_STEAL_EN
                    steal_out         <= r_steal_flag;
`endif
                    r_state           <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifndef VOICE_STEAL_EN
    assign steal_out = 1'b0;
`endif

endmodule
